// File: rtl/channel_arbiter.sv
// Round-robin arbiter: N requesters share one channel, with parity screening and a busy timeout.
// Latency: one edge from req to ack/ch_valid, and back-to-back grants on a completing edge.
// Backpressure: ch_busy holds the offered item stable; the item is dropped after TIMEOUT cycles.

`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 3
`endif

module channel_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16,
  localparam int W      = `HDR_SZ + `PL_SZ + `ADDR_SZ,
  localparam int IDW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   item_in,
  output logic [N-1:0]     ack,
  output logic             ch_valid,
  output logic [W-1:0]     ch_item,
  input  logic             ch_busy,
  output logic [IDW-1:0]   gnt_id,
  output logic             parity_err,
  output logic             timeout_err
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           vld_q, vld_d;
  logic [W-1:0]   item_q, item_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic           perr_q, perr_d;
  logic           terr_q, terr_d;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [W-1:0]   win_item;
  logic           win_par_ok;
  logic           take;

  // Round-robin search upward from ptr+1; descending loop so the nearest requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr_q) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(ptr_q) + k) % N);
      end
    end
  end

  // Winner's item and its even-parity check (XOR over all W bits must be zero).
  always_comb begin
    win_item   = item_in[int'(win_idx)*W +: W];
    win_par_ok = ~(^win_item);
  end

  // Next-state logic: completion, busy wait / timeout drop, and capture of a new winner.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    vld_d   = vld_q;
    item_d  = item_q;
    gnt_d   = gnt_q;
    perr_d  = perr_q;
    terr_d  = terr_q;
    take    = 1'b0;

    case (state_q)
      IDLE: begin
        take = win_found;
      end
      XFER: begin
        if (!ch_busy) begin
          // Transfer completes; a new winner may be captured on the same edge.
          vld_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
          take    = win_found;
        end else if (cnt_q == TO_LAST) begin
          // Offered for TIMEOUT cycles without acceptance: drop it.
          vld_d   = 1'b0;
          cnt_d   = '0;
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase

    if (take) begin
      ptr_d          = win_idx;
      ack_d[win_idx] = 1'b1;
      if (win_par_ok) begin
        item_d  = win_item;
        gnt_d   = win_idx;
        vld_d   = 1'b1;
        cnt_d   = '0;
        state_d = XFER;
      end else begin
        // Corrupted item is acknowledged but never forwarded.
        perr_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset; ptr starts at N-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(N - 1);
      cnt_q   <= '0;
      ack_q   <= '0;
      vld_q   <= 1'b0;
      item_q  <= '0;
      gnt_q   <= '0;
      perr_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      vld_q   <= vld_d;
      item_q  <= item_d;
      gnt_q   <= gnt_d;
      perr_q  <= perr_d;
      terr_q  <= terr_d;
    end
  end

  assign ack         = ack_q;
  assign ch_valid    = vld_q;
  assign ch_item     = item_q;
  assign gnt_id      = gnt_q;
  assign parity_err  = perr_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_channel_arbiter.sv
// Directed and randomised checks of channel_arbiter with N=4, TIMEOUT=16.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Busy behaviour, timeouts, parity drops and fairness are checked against a small model.

`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 3
`endif

module tb_channel_arbiter;

  localparam int N   = 4;
  localparam int TO  = 16;
  localparam int W   = `HDR_SZ + `PL_SZ + `ADDR_SZ;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] item_in;
  logic [N-1:0]   ack;
  logic           ch_valid;
  logic [W-1:0]   ch_item;
  logic           ch_busy;
  logic [IDW-1:0] gnt_id;
  logic           parity_err;
  logic           timeout_err;

  int n_cmp = 0;
  int n_mis = 0;

  channel_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .item_in    (item_in),
    .ack        (ack),
    .ch_valid   (ch_valid),
    .ch_item    (ch_item),
    .ch_busy    (ch_busy),
    .gnt_id     (gnt_id),
    .parity_err (parity_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk_item(input logic [W-2:0] body, input bit good);
    logic p;
    p = good ? (^body) : ~(^body);
    return {p, body};
  endfunction

  task automatic set_item(input int i, input logic [W-1:0] v);
    item_in[i*W +: W] = v;
  endtask

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] r;
    r    = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  task automatic do_reset();
    reset   = 1'b1;
    req     = '0;
    ch_busy = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    req     = '1;
    ch_busy = 1'b0;
    for (int i = 0; i < N; i++) set_item(i, mk_item(W'(i + 5), 1'b1));
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (ack !== '0) begin n_mis++; $display("FAIL reset_ack: got %b want 0", ack); end
      n_cmp++;
      if (ch_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", ch_valid); end
      n_cmp++;
      if (ch_item !== '0 || gnt_id !== '0) begin
        n_mis++; $display("FAIL reset_item_gnt: got %h/%0d want 0/0", ch_item, gnt_id);
      end
      n_cmp++;
      if (parity_err !== 1'b0 || timeout_err !== 1'b0) begin
        n_mis++; $display("FAIL reset_errs: got %b%b want 00", parity_err, timeout_err);
      end
    end
    req   = '0;
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [W-1:0] it [N];
    int w;
    do_reset();
    for (int i = 0; i < N; i++) begin
      it[i] = mk_item((W-1)'(14'h01A3 * (i + 1)), 1'b1);
      set_item(i, it[i]);
    end
    req = 4'b1111;
    ch_busy = 1'b0;
    for (int g = 0; g < 5; g++) begin
      step();
      w = g % N;
      n_cmp++;
      if (ack !== onehot(w)) begin n_mis++; $display("FAIL rr_ack[%0d]: got %b want %b", g, ack, onehot(w)); end
      n_cmp++;
      if (ch_valid !== 1'b1) begin n_mis++; $display("FAIL rr_valid[%0d]: got %b want 1", g, ch_valid); end
      n_cmp++;
      if (gnt_id !== IDW'(w)) begin n_mis++; $display("FAIL rr_gnt[%0d]: got %0d want %0d", g, gnt_id, w); end
      n_cmp++;
      if (ch_item !== it[w]) begin n_mis++; $display("FAIL rr_item[%0d]: got %h want %h", g, ch_item, it[w]); end
    end
    req = '0;
    step();
    n_cmp++;
    if (ch_valid !== 1'b0 || ack !== '0) begin
      n_mis++; $display("FAIL rr_drain: got valid=%b ack=%b want 0/0", ch_valid, ack);
    end
  endtask

  task automatic test_timeout();
    int vcnt;
    do_reset();
    set_item(2, mk_item(14'h2ABC, 1'b1));
    req = 4'b0100;
    ch_busy = 1'b1;
    step();
    n_cmp++;
    if (ack !== 4'b0100 || ch_valid !== 1'b1) begin
      n_mis++; $display("FAIL to_capture: got ack=%b valid=%b want 0100/1", ack, ch_valid);
    end
    req = '0;
    vcnt = 1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ch_valid === 1'b1) vcnt++;
      n_cmp++;
      if (ack !== '0) begin n_mis++; $display("FAIL to_ack[%0d]: got %b want 0", c, ack); end
    end
    n_cmp++;
    if (vcnt != TO) begin n_mis++; $display("FAIL to_valid_cycles: got %0d want %0d", vcnt, TO); end
    n_cmp++;
    if (timeout_err !== 1'b1) begin n_mis++; $display("FAIL to_err: got %b want 1", timeout_err); end
    req = 4'b0100;
    ch_busy = 1'b0;
    step();
    req = '0;
    n_cmp++;
    if (ack !== 4'b0100 || gnt_id !== 2'd2 || ch_valid !== 1'b1) begin
      n_mis++; $display("FAIL to_regrant: got ack=%b gnt=%0d valid=%b want 0100/2/1", ack, gnt_id, ch_valid);
    end
    n_cmp++;
    if (timeout_err !== 1'b1) begin n_mis++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    step();
  endtask

  task automatic test_parity();
    logic [W-1:0] good;
    do_reset();
    set_item(1, mk_item(14'h1357, 1'b0));
    req = 4'b0010;
    step();
    n_cmp++;
    if (ack !== 4'b0010 || ch_valid !== 1'b0) begin
      n_mis++; $display("FAIL par_bad: got ack=%b valid=%b want 0010/0", ack, ch_valid);
    end
    n_cmp++;
    if (parity_err !== 1'b1) begin n_mis++; $display("FAIL par_err: got %b want 1", parity_err); end
    good = mk_item(14'h0246, 1'b1);
    set_item(1, good);
    step();
    req = '0;
    n_cmp++;
    if (ack !== 4'b0010 || ch_valid !== 1'b1 || gnt_id !== 2'd1) begin
      n_mis++; $display("FAIL par_good: got ack=%b valid=%b gnt=%0d want 0010/1/1", ack, ch_valid, gnt_id);
    end
    n_cmp++;
    if (ch_item !== good) begin n_mis++; $display("FAIL par_item: got %h want %h", ch_item, good); end
    n_cmp++;
    if (parity_err !== 1'b1) begin n_mis++; $display("FAIL par_sticky: got %b want 1", parity_err); end
    step();
  endtask

  task automatic test_busy_hold();
    logic [W-1:0] x;
    do_reset();
    x = mk_item(14'h3C5A, 1'b1);
    set_item(0, x);
    req = 4'b0001;
    ch_busy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      req = '0;
      if (c == 3) ch_busy = 1'b0;
      n_cmp++;
      if (ch_item !== x || ch_valid !== 1'b1) begin
        n_mis++; $display("FAIL hold[%0d]: got %h/%b want %h/1", c, ch_item, ch_valid, x);
      end
    end
    step();
    n_cmp++;
    if (ch_valid !== 1'b0 || timeout_err !== 1'b0) begin
      n_mis++; $display("FAIL hold_done: got valid=%b terr=%b want 0/0", ch_valid, timeout_err);
    end
  endtask

  task automatic test_reset_mid_xfer();
    do_reset();
    set_item(3, mk_item(14'h0F0F, 1'b0));
    req = 4'b1000;
    step();
    set_item(3, mk_item(14'h0A0A, 1'b1));
    set_item(2, mk_item(14'h1111, 1'b1));
    set_item(1, mk_item(14'h2222, 1'b1));
    req = 4'b0100;
    ch_busy = 1'b1;
    step();
    req = '0;
    step();
    n_cmp++;
    if (ch_valid !== 1'b1 || parity_err !== 1'b1) begin
      n_mis++; $display("FAIL mid_setup: got valid=%b perr=%b want 1/1", ch_valid, parity_err);
    end
    reset = 1'b1;
    req = 4'b1010;
    ch_busy = 1'b0;
    step();
    reset = 1'b0;
    n_cmp++;
    if (ch_valid !== 1'b0 || ack !== '0) begin
      n_mis++; $display("FAIL mid_rst: got valid=%b ack=%b want 0/0", ch_valid, ack);
    end
    n_cmp++;
    if (parity_err !== 1'b0 || timeout_err !== 1'b0) begin
      n_mis++; $display("FAIL mid_errs: got %b%b want 00", parity_err, timeout_err);
    end
    step();
    req = '0;
    n_cmp++;
    if (ack !== 4'b0010 || gnt_id !== 2'd1) begin
      n_mis++; $display("FAIL mid_regrant: got ack=%b gnt=%0d want 0010/1", ack, gnt_id);
    end
    step();
  endtask

  task automatic test_random();
    logic [N-1:0]   p_req;
    logic           p_busy, p_vld;
    logic [N*W-1:0] p_items;
    logic [W-1:0]   pi;
    int             starve [N];
    int             w;
    do_reset();
    for (int i = 0; i < N; i++) starve[i] = 0;
    for (int i = 0; i < N; i++) set_item(i, mk_item((W-1)'($urandom), 1'b1));
    for (int c = 0; c < 10000; c++) begin
      p_req   = req;
      p_busy  = ch_busy;
      p_vld   = ch_valid;
      p_items = item_in;
      step();
      n_cmp++;
      if ((ack & (ack - 4'd1)) !== '0) begin n_mis++; $display("FAIL rnd_onehot[%0d]: got %b", c, ack); end
      n_cmp++;
      if ((ack & ~p_req) !== '0) begin
        n_mis++; $display("FAIL rnd_unreq[%0d]: got ack=%b req=%b", c, ack, p_req);
      end
      if (p_vld && p_busy) begin
        n_cmp++;
        if (ack !== '0) begin n_mis++; $display("FAIL rnd_busy_ack[%0d]: got %b want 0", c, ack); end
      end
      if (ack !== '0) begin
        w = 0;
        for (int i = 0; i < N; i++) if (ack[i]) w = i;
        pi = p_items[w*W +: W];
        n_cmp++;
        if (^pi === 1'b0) begin
          if (ch_valid !== 1'b1 || gnt_id !== IDW'(w) || ch_item !== pi) begin
            n_mis++;
            $display("FAIL rnd_fwd[%0d]: got %b/%0d/%h want 1/%0d/%h", c, ch_valid, gnt_id, ch_item, w, pi);
          end
        end else if (ch_valid !== 1'b0) begin
          n_mis++; $display("FAIL rnd_par[%0d]: got valid=%b want 0", c, ch_valid);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!p_req[i] || ack[i]) starve[i] = 0;
        else if (ack !== '0) starve[i]++;
        if (starve[i] > N - 1) begin
          n_cmp++;
          n_mis++;
          $display("FAIL rnd_starve[%0d]: port %0d got %0d grants ahead, want <= %0d", c, i, starve[i], N - 1);
          starve[i] = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 3) == 0) set_item(i, mk_item((W-1)'($urandom), $urandom_range(0, 9) != 0));
      end
      ch_busy = ($urandom_range(0, 2) == 0);
    end
    req = '0;
    ch_busy = 1'b0;
    step();
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    ch_busy = 1'b0;
    item_in = '0;
    #1;
    test_reset();
    test_round_robin();
    test_timeout();
    test_parity();
    test_busy_hold();
    test_reset_mid_xfer();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/channel_arbiter.md
CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 Parameter N, default 4: number of network-interface requesters sharing one channel; legal values 2..8.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles an item waits on a busy channel before it is dropped; legal values 2..255.
REQ-003 Derived width W = `HDR_SZ + `PL_SZ + `ADDR_SZ; item bit W-1 is the parity bit and bits W-2:0 are {header, payload, dest}.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  N  req[i]=1: requester i presents a valid item.
REQ-007 item_in  in  N*W  flattened items; requester i occupies bits [i*W +: W].
REQ-008 ack  out  N  one-cycle pulse: item of requester i captured by the arbiter.
REQ-009 ch_valid  out  1  ch_item holds an item offered to the channel.
REQ-010 ch_item  out  W  item driven onto the shared channel.
REQ-011 ch_busy  in  1  downstream channel cannot accept this cycle.
REQ-012 gnt_id  out  clog2(N)  index of the requester whose item is in ch_item.
REQ-013 parity_err  out  1  sticky flag: a captured item failed parity.
REQ-014 timeout_err  out  1  sticky flag: an item was dropped on timeout.

Function
REQ-015 FSM states: IDLE (no item held) and XFER (item held, ch_valid=1).
REQ-016 In IDLE with any req bit set, the arbiter selects winner w by round-robin, searching upward from ptr+1 modulo N, where ptr is the last winner.
REQ-017 On selection, in the same edge, the arbiter: sets ptr<=w and pulses ack[w] for exactly one cycle; checks parity; if XOR of all W bits of item w is 0, it sets ch_item<=item w, gnt_id<=w, ch_valid<=1 and moves to XFER.
REQ-018 Parity failure: item is not forwarded, parity_err<=1, ack[w] still pulses, state remains IDLE.
REQ-019 In XFER with ch_busy=0, the transfer completes on that edge: wait counter clears and ch_valid drops.
REQ-020 Back-to-back: on a completing edge with any req set, the arbiter applies REQ-016/017 in the same edge, so ch_valid stays 1 with no bubble.
REQ-021 In XFER with ch_busy=1, a wait counter increments; ch_item, gnt_id and ch_valid hold stable.
REQ-022 When the wait counter reaches TIMEOUT-1 with ch_busy still 1, the item is dropped: ch_valid<=0, timeout_err<=1, state<=IDLE. The item is therefore offered for at most TIMEOUT cycles.
REQ-023 No ack pulses while in XFER unless the completing-edge case of REQ-020 applies.
REQ-024 At most one ack bit is set in any cycle.
REQ-025 A req bit that deasserts before capture has no effect and no memory.
REQ-026 item_in of non-winners is ignored.
REQ-027 The round-robin pointer wraps from N-1 to 0.
REQ-028 A requester holding req high continuously is served at least once every N grants.
REQ-029 parity_err and timeout_err clear only on reset.
REQ-030 ch_item and gnt_id are registered outputs. ack and ch_valid are registered outputs.

Reset
REQ-031 With reset=1 at a clock edge, the following take effect on that edge regardless of state, including mid-XFER, where the held item is discarded:
- state<=IDLE
- ch_valid<=0, ch_item<=0, gnt_id<=0
- ack<=0
- parity_err<=0, timeout_err<=0
- wait counter<=0
- ptr<=N-1, so requester 0 has first priority.
REQ-032 While reset is high, no ack is issued.

Verification
REQ-033 After reset, req=4'b1111, all items with good parity, ch_busy=0 -> ack order 0,1,2,3,0. ch_valid stays 1 continuously from the first capture. gnt_id follows 0,1,2,3.
REQ-034 req=4'b0100, ch_busy held at 1 with TIMEOUT=16 -> ch_valid is high for exactly 16 cycles, then drops. timeout_err=1 and stays 1. The next grant goes to port 2 only if req[2] is still set.
REQ-035 req[1] with an item of odd total parity -> ack[1] pulses, ch_valid stays 0 and parity_err=1. A following good item on port 1 is forwarded normally.
REQ-036 Item held with ch_busy=1 for 3 cycles, then ch_busy=0 -> ch_item is unchanged across all 4 cycles. The transfer completes on the 4th edge and timeout_err stays 0.
REQ-037 reset asserted in the middle of XFER -> next cycle ch_valid=0, both error flags 0, and the next grant goes to the lowest requesting index.
REQ-038 Random req/ch_busy run of 10k cycles, with a checker -> every forwarded item equals the acked requester's item, no requester is starved for more than N grants, and never more than one ack bit is set.
